uart_tx_ctrl: RTL and testbench

UART transmit controller that sequences one serial frame per accepted byte: start bit, WIDTH data bits LSB-first, optional parity bit, stop bit. It owns the frame FSM, the data-bit counter, the shift register, the internal parity computation and the output mux. The TX top level instantiates it, driven at one bit per clk (clk is the baud tick clock).

---
 rtl/uart_tx_ctrl_if.sv | 12 +
 rtl/uart_tx_ctrl.sv | 89 ++++++++
 tb/tb_uart_tx_ctrl.sv | 139 +++++++++++++
 3 files changed

// File: rtl/uart_tx_ctrl_if.sv
// Request and serial-line signals between a UART TX requester and uart_tx_ctrl.
interface uart_tx_ctrl_if #(parameter int WIDTH = 8);
  logic             Data_valid;
  logic [WIDTH-1:0] P_data;
  logic             Par_en;
  logic             Par_type;
  logic             TX_OUT;
  logic             Busy;

  modport master (output Data_valid, P_data, Par_en, Par_type, input TX_OUT, Busy);
  modport slave  (input Data_valid, P_data, Par_en, Par_type, output TX_OUT, Busy);
endinterface

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: start, WIDTH data bits LSB-first, optional parity, stop.
// Outputs are registered together with the next state, so each bit shows the cycle after its edge.
module uart_tx_ctrl #(
  parameter int WIDTH = 8
) (
  input logic          clk,
  input logic          rst,
  uart_tx_ctrl_if.slave bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] shift;
  logic             par_en_q;
  logic             par_bit;
  logic             tx_q;
  logic             busy_q;
  logic             accept;

  assign accept     = ((state == IDLE) || (state == STOP)) && bus.Data_valid;
  assign bus.TX_OUT = tx_q;
  assign bus.Busy   = busy_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      shift    <= '0;
      par_en_q <= 1'b0;
      par_bit  <= 1'b0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      case (state)
        IDLE, STOP: begin
          if (accept) begin
            state    <= START;
            shift    <= bus.P_data;
            par_en_q <= bus.Par_en;
            par_bit  <= bus.Par_type ? ~^bus.P_data : ^bus.P_data;
            tx_q     <= 1'b0;
            busy_q   <= 1'b1;
          end else begin
            state  <= IDLE;
            tx_q   <= 1'b1;
            busy_q <= 1'b0;
          end
        end
        // The first data bit is put on the line here, so DATA is entered already showing bit 0.
        START: begin
          state  <= DATA;
          cnt    <= '0;
          tx_q   <= shift[0];
          shift  <= shift >> 1;
          busy_q <= 1'b1;
        end
        DATA: begin
          busy_q <= 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            if (par_en_q) begin
              state <= PARITY;
              tx_q  <= par_bit;
            end else begin
              state <= STOP;
              tx_q  <= 1'b1;
            end
          end else begin
            cnt   <= cnt + 1'b1;
            tx_q  <= shift[0];
            shift <= shift >> 1;
          end
        end
        PARITY: begin
          state  <= STOP;
          tx_q   <= 1'b1;
          busy_q <= 1'b1;
        end
        default: begin
          state  <= IDLE;
          tx_q   <= 1'b1;
          busy_q <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed + random bench for uart_tx_ctrl against a queue-of-line-bits reference model.
module tb_uart_tx_ctrl;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_tx_ctrl_if #(.WIDTH(W)) bus ();
  uart_tx_ctrl #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int   errors = 0;
  int   checks = 0;
  bit   q[$];       // line bits still to be shown after future edges
  logic exp_tx;
  logic exp_busy;
  logic [10:0] seq;
  int   busy_cnt;

  // Whole frame as the line should show it, built from the frame rules.
  function automatic void load_frame(input logic [W-1:0] d, input logic pe, input logic pt);
    q.push_back(1'b0);
    for (int i = 0; i < W; i++) q.push_back(d[i]);
    if (pe) q.push_back(1'(($countones(d) % 2) != 0) ^ pt);
    q.push_back(1'b1);
  endfunction

  task automatic step(input logic r, input logic dv, input logic [W-1:0] d,
                      input logic pe, input logic pt, input string tag);
    rst            = r;
    bus.Data_valid = dv;
    bus.P_data     = d;
    bus.Par_en     = pe;
    bus.Par_type   = pt;
    @(posedge clk);
    if (r) begin
      q.delete();
    end else if (q.size() == 0 && dv) begin
      load_frame(d, pe, pt);
    end
    if (!r && q.size() > 0) begin
      exp_tx   = q.pop_front();
      exp_busy = 1'b1;
    end else begin
      exp_tx   = 1'b1;
      exp_busy = 1'b0;
    end
    #1;
    seq = {seq[9:0], bus.TX_OUT};
    if (bus.Busy === 1'b1) busy_cnt++;
    checks++;
    assert (bus.TX_OUT === exp_tx) else begin
      errors++;
      $error("FAIL %s tx got=%0b exp=%0b", tag, bus.TX_OUT, exp_tx);
    end
    checks++;
    assert (bus.Busy === exp_busy) else begin
      errors++;
      $error("FAIL %s busy got=%0b exp=%0b", tag, bus.Busy, exp_busy);
    end
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, $urandom_range(0, 255), 1'b1, 1'b1, tag);
  endtask

  initial begin
    bus.Data_valid = 1'b0;
    bus.P_data     = '0;
    bus.Par_en     = 1'b0;
    bus.Par_type   = 1'b0;
    seq            = '0;
    busy_cnt       = 0;

    // Reset with a request pending: reset wins.
    step(1'b1, 1'b1, 8'h77, 1'b1, 1'b0, "reset");
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, "reset");
    idle(20, "idle");

    // 0xA5 even parity: explicit line sequence and Busy length.
    busy_cnt = 0;
    step(1'b0, 1'b1, 8'hA5, 1'b1, 1'b0, "a5");
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, "a5");
    checks++;
    assert (seq === 11'b01010010101) else begin
      errors++;
      $error("FAIL a5_seq got=%b exp=%b", seq, 11'b01010010101);
    end
    idle(3, "a5_tail");
    checks++;
    assert (busy_cnt === 11) else begin
      errors++;
      $error("FAIL a5_busy_len got=%0d exp=11", busy_cnt);
    end

    // Odd parity on 0x01 then 0x00.
    step(1'b0, 1'b1, 8'h01, 1'b1, 1'b1, "odd01");
    idle(12, "odd01");
    step(1'b0, 1'b1, 8'h00, 1'b1, 1'b1, "odd00");
    idle(12, "odd00");

    // 0xFF with no parity: 10-cycle frame.
    busy_cnt = 0;
    step(1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, "ff");
    idle(12, "ff");
    checks++;
    assert (busy_cnt === 10) else begin
      errors++;
      $error("FAIL ff_busy_len got=%0d exp=10", busy_cnt);
    end

    // Back-to-back: 0xC3 held through STOP; 0x00 pulsed mid-DATA must be ignored.
    step(1'b0, 1'b1, 8'h3C, 1'b1, 1'b0, "b2b_a");
    for (int i = 0; i < 9; i++) step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, "b2b_a");
    step(1'b0, 1'b1, 8'hC3, 1'b1, 1'b0, "b2b_hold");
    step(1'b0, 1'b1, 8'hC3, 1'b1, 1'b0, "b2b_stop");
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, "b2b_b");
    step(1'b0, 1'b1, 8'h00, 1'b0, 1'b1, "b2b_ignored");
    idle(10, "b2b_b");

    // Reset during the 4th data bit, then a clean 0x5A frame.
    step(1'b0, 1'b1, 8'h5A, 1'b1, 1'b0, "abort");
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, "abort");
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, "abort_rst");
    idle(2, "post_rst");
    step(1'b0, 1'b1, 8'h5A, 1'b1, 1'b0, "5a");
    idle(12, "5a");

    // Random traffic with occasional resets.
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 59) == 0), 1'($urandom_range(0, 3) == 0),
           8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), "rand");
    idle(12, "drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
